chip8_sprite_draw: RTL
======================

Name: chip8_sprite_draw

Overview:
- Executes the CHIP-8 DXYN draw and 00E0 clear operations on behalf of the top-level controller.
- Sits between the controller, the Chip8_memory read port and the Framebuffer pixel port.
- Fetches N sprite bytes from address I, XORs them into the 64x32 monochrome framebuffer with wrap-around, and reports collision for VF.
- Uses a start/busy/done handshake so the controller stalls PC advance while a draw is in progress.

Parameters:
- W_LOG2, 6, log2 of screen width (64).
- H_LOG2, 5, log2 of screen height (32).
- ADDR_W, 12, memory address width (4 KiB).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle draw request; sampled only in IDLE
- clear  in  1  one-cycle clear request; sampled only in IDLE
- x  in  8  VX; only [W_LOG2-1:0] used
- y  in  8  VY; only [H_LOG2-1:0] used
- n  in  4  sprite height in rows
- i  in  16  sprite base address; only [ADDR_W-1:0] used
- busy  out  1  high from the cycle after an accepted request through the DONE cycle
- done  out  1  one-cycle pulse at completion
- collision  out  1  valid while done=1; held until the next accepted request
- mem_addr  out  ADDR_W  sprite byte address
- mem_re  out  1  read strobe
- mem_rdata  in  8  read data, valid the cycle after mem_re
- fb_addr  out  W_LOG2+H_LOG2  pixel index {y,x}
- fb_re  out  1  pixel read strobe
- fb_rdata  in  1  pixel value, valid the cycle after fb_re
- fb_we  out  1  pixel write strobe
- fb_wdata  out  1  pixel write value

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - busy, done, collision, mem_re, fb_re and fb_we all 0; mem_addr and fb_addr 0.
  - Reset mid-operation aborts immediately. No further fb writes; pixels already written stay as written.
- States: IDLE, MEM_REQ, MEM_WAIT, PIX_CHK, PIX_RMW, CLR, DONE.
- IDLE:
  - clear=1 goes to CLR. If clear and start are both high, clear wins.
  - start=1 with n!=0 latches x mod 64, y mod 32, n, i[11:0]; row=0, collision=0; goes to MEM_REQ.
  - start=1 with n=0 goes straight to DONE with collision=0.
  - Requests arriving in any other state are ignored; they are not queued.
- MEM_REQ: mem_addr=(i+row) mod 4096, mem_re=1; goes to MEM_WAIT.
- MEM_WAIT: capture mem_rdata into the sprite shift register; col=0; goes to PIX_CHK.
- PIX_CHK:
  - Bit examined is sprite[7-col] (MSB is leftmost).
  - Bit=0: no fb access; advance col.
  - Bit=1: fb_addr={(y+row) mod 32,(x+col) mod 64}, fb_re=1; goes to PIX_RMW.
- PIX_RMW:
  - fb_addr is held; fb_we=1, fb_wdata=~fb_rdata.
  - collision |= fb_rdata; advance col.
- Column advance:
  - col<7: return to PIX_CHK.
  - col=7: row++. If row==n go to DONE, else go to MEM_REQ.
- Wrap rule: both the start coordinate and every individual pixel wrap modulo the screen size. Nothing is clipped.
- CLR:
  - fb_addr counts 0..2047, one address per cycle, with fb_we=1 and fb_wdata=0.
  - After address 2047, goes to DONE with collision=0.
- DONE: done=1 for exactly one cycle; goes to IDLE.
- Latency: counting the start-sample cycle as 0, done asserts in cycle 1+sum over rows of (10+popcount(byte)).
  - Example: n=1, byte=0x00 gives done in cycle 11.
  - Clear gives done in cycle 2049.
- Strobe rule: at most one of fb_re/fb_we is high in any cycle. mem_re is never high together with fb_we.

Decomposition:
- chip8_pkg holds:
  - the draw_state_t enum;
  - SCREEN_W=64, SCREEN_H=32, FB_AW=11, MEM_AW=12;
  - a pixel_index(x,y) function.
- No sub-module. The FSM, row/column counters and shift register fit in one module of roughly 200 lines.

Test Plan:
- Reset during PIX_RMW -> next cycle busy=0, fb_we=0; a subsequent start works normally.
- Empty framebuffer; mem[0x300]=0xF0; start x=0,y=0,n=1,i=0x300 -> pixels 0..3 become 1 and 4..7 stay 0; collision=0; done in cycle 15.
- Repeat the same draw -> pixels 0..3 back to 0; collision=1.
- x=62, y=31, n=2, bytes 0xFF,0x81 ->
  - row 31 sets pixels at x=62,63,0..5;
  - row 0 (wrapped) sets pixels at x=62 and x=5.
- x=70, y=40 draws at (6,8); i=0xFFF,n=2 fetches 0xFFF then 0x000.
- clear and start asserted together -> clear runs, 2048 zero writes, done at cycle 2049, collision=0; a start pulse during busy is ignored.
- n=0 -> done in cycle 1, no mem/fb strobes.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite draw engine.
// Screen geometry, memory width and the pixel index helper live here.
package chip8_pkg;

    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;
    localparam int FB_AW    = 11;
    localparam int MEM_AW   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_PIX_CHK,
        S_PIX_RMW,
        S_CLR,
        S_DONE
    } draw_state_t;

    function automatic logic [FB_AW-1:0] pixel_index(
        input logic [5:0] px,
        input logic [4:0] py
    );
        return {py, px};
    endfunction

endpackage

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite draw and 00E0 clear engine.
// Fetches sprite rows, XORs them into the framebuffer with wrap, reports collision.
module chip8_sprite_draw
    import chip8_pkg::*;
#(
    parameter int W_LOG2 = 6,
    parameter int H_LOG2 = 5,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
    input  logic [7:0]                 x,
    input  logic [7:0]                 y,
    input  logic [3:0]                 n,
    input  logic [15:0]                i,
    output logic                       busy,
    output logic                       done,
    output logic                       collision,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_re,
    input  logic [7:0]                 mem_rdata,
    output logic [W_LOG2+H_LOG2-1:0]   fb_addr,
    output logic                       fb_re,
    input  logic                       fb_rdata,
    output logic                       fb_we,
    output logic                       fb_wdata
);

    draw_state_t                r_state;
    logic [W_LOG2-1:0]          r_x;
    logic [H_LOG2-1:0]          r_y;
    logic [3:0]                 r_n;
    logic [ADDR_W-1:0]          r_i;
    logic [3:0]                 r_row;
    logic [2:0]                 r_col;
    logic [7:0]                 r_sprite;
    logic [W_LOG2+H_LOG2-1:0]   r_clr_addr;
    logic                       r_coll;

    logic [W_LOG2-1:0]          w_px;
    logic [H_LOG2-1:0]          w_py;
    logic                       w_bit;
    logic                       w_last_col;
    logic [3:0]                 w_row_next;
    draw_state_t                w_adv_state;
    logic                       w_unused;

    assign w_unused = &{1'b0, x[7:W_LOG2], y[7:H_LOG2], i[15:ADDR_W]};

    assign w_px       = r_x + {{(W_LOG2-3){1'b0}}, r_col};
    assign w_py       = r_y + {{(H_LOG2-4){1'b0}}, r_row};
    assign w_bit      = r_sprite[3'd7 - r_col];
    assign w_last_col = (r_col == 3'd7);
    assign w_row_next = r_row + 4'd1;

    // Column advance is shared by the skip path and the read-modify-write path
    always_comb begin
        w_adv_state = S_PIX_CHK;
        if (w_last_col)
            w_adv_state = (w_row_next == r_n) ? S_DONE : S_MEM_REQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_n        <= '0;
            r_i        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_sprite   <= '0;
            r_clr_addr <= '0;
            r_coll     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_clr_addr <= '0;
                        r_coll     <= 1'b0;
                        r_state    <= S_CLR;
                    end else if (start) begin
                        r_coll <= 1'b0;
                        r_x    <= x[W_LOG2-1:0];
                        r_y    <= y[H_LOG2-1:0];
                        r_n    <= n;
                        r_i    <= i[ADDR_W-1:0];
                        r_row  <= '0;
                        r_state <= (n == 4'd0) ? S_DONE : S_MEM_REQ;
                    end
                end
                S_MEM_REQ: r_state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    r_sprite <= mem_rdata;
                    r_col    <= '0;
                    r_state  <= S_PIX_CHK;
                end
                S_PIX_CHK: begin
                    if (w_bit) begin
                        r_state <= S_PIX_RMW;
                    end else begin
                        r_col   <= r_col + 3'd1;
                        r_row   <= w_last_col ? w_row_next : r_row;
                        r_state <= w_adv_state;
                    end
                end
                S_PIX_RMW: begin
                    r_coll  <= r_coll | fb_rdata;
                    r_col   <= r_col + 3'd1;
                    r_row   <= w_last_col ? w_row_next : r_row;
                    r_state <= w_adv_state;
                end
                S_CLR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr)
                        r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign collision = r_coll;
    assign mem_re    = (r_state == S_MEM_REQ);
    assign mem_addr  = mem_re ? r_i + {{(ADDR_W-4){1'b0}}, r_row} : '0;
    assign fb_re     = (r_state == S_PIX_CHK) && w_bit;
    assign fb_we     = (r_state == S_PIX_RMW) || (r_state == S_CLR);
    assign fb_wdata  = (r_state == S_PIX_RMW) ? ~fb_rdata : 1'b0;

    always_comb begin
        fb_addr = '0;
        if (r_state == S_CLR)
            fb_addr = r_clr_addr;
        else if (r_state == S_PIX_CHK || r_state == S_PIX_RMW)
            fb_addr = pixel_index(w_px, w_py);
    end

endmodule
